// File: rtl/tlul_timer.sv
// TL-UL timer peripheral: 64-bit prescaled free-running counter, 64-bit compare,
// level interrupt, and a single-outstanding registered D-channel responder.

package tlul_pkg;

  localparam logic [2:0] OpPutFull       = 3'h0;
  localparam logic [2:0] OpPutPartial    = 3'h1;
  localparam logic [2:0] OpGet           = 3'h4;
  localparam logic [2:0] OpAccessAck     = 3'h0;
  localparam logic [2:0] OpAccessAckData = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_timer
  import tlul_pkg::*;
#(
  parameter int unsigned PrescW = 16
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output logic    irq_o
);

  typedef enum logic [2:0] {
    RegCtrl   = 3'd0,
    RegPresc  = 3'd1,
    RegCntLo  = 3'd2,
    RegCntHi  = 3'd3,
    RegCmpLo  = 3'd4,
    RegCmpHi  = 3'd5,
    RegStatus = 3'd6
  } reg_idx_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Register state
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic [PrescW-1:0] prescale_q, prescale_d;
  logic [PrescW-1:0] presc_cnt_q, presc_cnt_d;
  logic [63:0]       count_q, count_d;
  logic [63:0]       cmp_q, cmp_d;
  logic [31:0]       shadow_q, shadow_d;
  logic              pending_q, pending_d;

  // Response state
  logic              rsp_valid_q, rsp_valid_d;
  logic [2:0]        rsp_opcode_q, rsp_opcode_d;
  logic [1:0]        rsp_size_q, rsp_size_d;
  logic [7:0]        rsp_source_q, rsp_source_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;

  // Request decode
  logic [11:0] offset;
  reg_idx_e    reg_sel;
  logic        is_get, is_put, req_err;
  logic        accept, wr_en, rd_en;

  assign offset  = tl_i.a_address[11:0];
  assign reg_sel = reg_idx_e'(offset[4:2]);
  assign is_get  = (tl_i.a_opcode == OpGet);
  assign is_put  = (tl_i.a_opcode == OpPutFull) || (tl_i.a_opcode == OpPutPartial);
  assign req_err = !(is_get || is_put) || (offset[1:0] != 2'b00) ||
                   (tl_i.a_size > 2'd2) || (offset > 12'h018);
  assign accept  = tl_i.a_valid && !rsp_valid_q;
  assign wr_en   = accept && is_put && !req_err;
  assign rd_en   = accept && is_get && !req_err;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:12]};

  logic [31:0] presc_ext;
  always_comb begin
    presc_ext = '0;
    presc_ext[PrescW-1:0] = prescale_q;
  end

  // Read mux: values as they stand in the accept cycle.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegCtrl:   rdata = {30'b0, irq_en_q, enable_q};
      RegPresc:  rdata = presc_ext;
      RegCntLo:  rdata = count_q[31:0];
      RegCntHi:  rdata = shadow_q;
      RegCmpLo:  rdata = cmp_q[31:0];
      RegCmpHi:  rdata = cmp_q[63:32];
      RegStatus: rdata = {31'b0, pending_q};
      default:   rdata = '0;
    endcase
  end

  logic        tick;
  logic        status_clr;
  logic [31:0] presc_wr;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    prescale_d  = prescale_q;
    cmp_d       = cmp_q;
    shadow_d    = shadow_q;
    status_clr  = 1'b0;
    presc_wr    = presc_ext;
    presc_cnt_d = presc_cnt_q;

    tick = enable_q && (presc_cnt_q == prescale_q);
    if (enable_q) presc_cnt_d = tick ? '0 : presc_cnt_q + PrescW'(1);
    count_d = tick ? count_q + 64'd1 : count_q;

    if (rd_en && reg_sel == RegCntLo) shadow_d = count_q[63:32];

    // Counter writes merge over the incremented value so a same-cycle tick
    // survives in the bytes that were not written.
    if (wr_en) begin
      case (reg_sel)
        RegCtrl: if (tl_i.a_mask[0]) {irq_en_d, enable_d} = tl_i.a_data[1:0];
        RegPresc: begin
          presc_wr   = byte_merge(presc_ext, tl_i.a_data, tl_i.a_mask);
          prescale_d = presc_wr[PrescW-1:0];
        end
        RegCntLo:  count_d[31:0]  = byte_merge(count_d[31:0], tl_i.a_data, tl_i.a_mask);
        RegCntHi:  count_d[63:32] = byte_merge(count_d[63:32], tl_i.a_data, tl_i.a_mask);
        RegCmpLo:  cmp_d[31:0]    = byte_merge(cmp_q[31:0], tl_i.a_data, tl_i.a_mask);
        RegCmpHi:  cmp_d[63:32]   = byte_merge(cmp_q[63:32], tl_i.a_data, tl_i.a_mask);
        RegStatus: status_clr     = tl_i.a_mask[0] && tl_i.a_data[0];
        default: ;
      endcase
    end

    pending_d = (enable_q && (count_q >= cmp_q)) || (pending_q && !status_clr);
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_size_d   = rsp_size_q;
    rsp_source_d = rsp_source_q;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_opcode_d = is_get ? OpAccessAckData : OpAccessAck;
      rsp_size_d   = tl_i.a_size;
      rsp_source_d = tl_i.a_source;
      rsp_data_d   = rd_en ? rdata : '0;
      rsp_error_d  = req_err;
    end else if (rsp_valid_q && tl_i.d_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      prescale_q   <= '0;
      presc_cnt_q  <= '0;
      count_q      <= '0;
      cmp_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= '0;
      rsp_size_q   <= '0;
      rsp_source_q <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      prescale_q   <= prescale_d;
      presc_cnt_q  <= presc_cnt_d;
      count_q      <= count_d;
      cmp_q        <= cmp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_size_q   <= rsp_size_d;
      rsp_source_q <= rsp_source_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_valid_q;
    tl_o.d_opcode = rsp_opcode_q;
    tl_o.d_size   = rsp_size_q;
    tl_o.d_source = rsp_source_q;
    tl_o.d_data   = rsp_data_q;
    tl_o.d_error  = rsp_error_q;
    tl_o.a_ready  = !rsp_valid_q;
  end

  assign irq_o = pending_q && irq_en_q;

endmodule

// File: tb/tb_tlul_timer.sv
// Directed bench for tlul_timer: register access, prescaled counting, snapshot,
// interrupt, error responses, back-pressure and asynchronous reset.

module tb_tlul_timer;
  import tlul_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic    irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] r_data;
  logic        r_err;
  logic [2:0]  r_op;

  always #5 clk = ~clk;

  tlul_timer #(.PrescW(16)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tl_i  (tl_i),
    .tl_o  (tl_o),
    .irq_o (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic xact(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] mask, input logic [1:0] size,
                      input logic [7:0] src, output logic [31:0] rdata, output logic err,
                      output logic [2:0] dop);
    int n = 0;
    @(negedge clk);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = addr;
    tl_i.a_data    = data;
    tl_i.a_mask    = mask;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.d_ready   = 1'b1;
    while (!tl_o.a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":a_ready"}, 64'(tl_o.a_ready), 64'd1);
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    check({tag, ":d_valid"}, 64'(tl_o.d_valid), 64'd1);
    check({tag, ":d_source"}, 64'(tl_o.d_source), 64'(src));
    check({tag, ":d_size"}, 64'(tl_o.d_size), 64'(size));
    check({tag, ":zero_fields"}, 64'({tl_o.d_param, tl_o.d_sink, tl_o.d_user}), 64'd0);
    rdata = tl_o.d_data;
    err   = tl_o.d_error;
    dop   = tl_o.d_opcode;
    @(posedge clk); #1;
    check({tag, ":d_valid_drop"}, 64'(tl_o.d_valid), 64'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    xact(tag, OpGet, addr, 32'h0, 4'hF, 2'd2, 8'h3C, d, e, o);
    check({tag, ":err"}, 64'(e), 64'd0);
    check({tag, ":opcode"}, 64'(o), 64'(OpAccessAckData));
    check({tag, ":data"}, 64'(d), 64'(exp));
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    xact(tag, OpPutFull, addr, data, 4'hF, 2'd2, 8'h42, d, e, o);
    check({tag, ":err"}, 64'(e), 64'd0);
    check({tag, ":opcode"}, 64'(o), 64'(OpAccessAck));
  endtask

  initial begin
    tl_i         = '0;
    tl_i.d_ready = 1'b1;
    rst_n        = 1'b0;
    #2;
    check("rst:d_valid", 64'(tl_o.d_valid), 64'd0);
    check("rst:a_ready", 64'(tl_o.a_ready), 64'd1);
    check("rst:irq", 64'(irq), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First read after reset, source echoed.
    xact("get_cnt_lo", OpGet, 32'h008, 32'h0, 4'hF, 2'd2, 8'h5A, r_data, r_err, r_op);
    check("get_cnt_lo:opcode", 64'(r_op), 64'(OpAccessAckData));
    check("get_cnt_lo:data", 64'(r_data), 64'd0);
    check("get_cnt_lo:err", 64'(r_err), 64'd0);

    // Prescale 3: COUNT advances once every 4 enabled cycles.
    wr("presc3", 32'h004, 32'd3);
    wr("enable", 32'h000, 32'h1);
    repeat (40) @(posedge clk);
    rd("count_40", 32'h008, 32'd10);
    wr("disable", 32'h000, 32'h0);
    rd("count_held", 32'h008, 32'd11);
    rd("count_hi0", 32'h00C, 32'd0);

    // Byte masks and unimplemented bits.
    xact("cmp_partial", OpPutPartial, 32'h010, 32'hAABBCCDD, 4'h5, 2'd2, 8'h07, r_data, r_err, r_op);
    check("cmp_partial:err", 64'(r_err), 64'd0);
    rd("cmp_lo_rb", 32'h010, 32'h00BB00DD);
    wr("presc_wide", 32'h004, 32'hFFFF1234);
    rd("presc_rb", 32'h004, 32'h00001234);
    wr("presc0", 32'h004, 32'd0);

    // 32-bit carry and HI snapshot.
    wr("cnt_lo_ff", 32'h008, 32'hFFFFFFFF);
    wr("cnt_hi_0", 32'h00C, 32'h0);
    wr("enable2", 32'h000, 32'h1);
    rd("carry_lo", 32'h008, 32'h0);
    rd("carry_hi", 32'h00C, 32'h1);

    // Compare interrupt.
    wr("disable2", 32'h000, 32'h0);
    wr("cnt_lo_0", 32'h008, 32'h0);
    wr("cnt_hi_0b", 32'h00C, 32'h0);
    wr("cmp_lo_5", 32'h010, 32'd5);
    wr("cmp_hi_0", 32'h014, 32'h0);
    wr("clr0", 32'h018, 32'h1);
    rd("status0", 32'h018, 32'h0);
    check("irq_idle", 64'(irq), 64'd0);
    wr("ctrl3", 32'h000, 32'h3);
    repeat (4) @(posedge clk); #1;
    check("irq_before", 64'(irq), 64'd0);
    @(posedge clk); #1;
    check("irq_rise", 64'(irq), 64'd1);
    wr("clr_while_set", 32'h018, 32'h1);
    check("irq_set_wins", 64'(irq), 64'd1);
    rd("status1", 32'h018, 32'h1);
    wr("cmp_lo_max", 32'h010, 32'hFFFFFFFF);
    wr("cmp_hi_max", 32'h014, 32'hFFFFFFFF);
    wr("clr1", 32'h018, 32'h1);
    check("irq_cleared", 64'(irq), 64'd0);
    rd("status_cleared", 32'h018, 32'h0);

    // Error responses.
    xact("err_get_1c", OpGet, 32'h01C, 32'h0, 4'hF, 2'd2, 8'h01, r_data, r_err, r_op);
    check("err_get_1c:err", 64'(r_err), 64'd1);
    check("err_get_1c:opcode", 64'(r_op), 64'(OpAccessAckData));
    check("err_get_1c:data", 64'(r_data), 64'd0);
    xact("err_put_06", OpPutFull, 32'h006, 32'hFFFF, 4'hF, 2'd2, 8'h02, r_data, r_err, r_op);
    check("err_put_06:err", 64'(r_err), 64'd1);
    check("err_put_06:opcode", 64'(r_op), 64'(OpAccessAck));
    rd("err_put_06:presc", 32'h004, 32'h0);
    xact("err_op3", 3'd3, 32'h000, 32'h0, 4'hF, 2'd2, 8'h03, r_data, r_err, r_op);
    check("err_op3:err", 64'(r_err), 64'd1);
    check("err_op3:opcode", 64'(r_op), 64'(OpAccessAck));
    check("err_op3:data", 64'(r_data), 64'd0);
    rd("err_op3:ctrl", 32'h000, 32'h3);
    xact("err_size3", OpGet, 32'h000, 32'h0, 4'hF, 2'd3, 8'h04, r_data, r_err, r_op);
    check("err_size3:err", 64'(r_err), 64'd1);
    rd("upper_addr_ignored", 32'hABCD5004, 32'h0);

    // Back-pressure: response held while d_ready=0, a_valid held high.
    @(negedge clk);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = OpGet;
    tl_i.a_address = 32'h000;
    tl_i.a_size    = 2'd2;
    tl_i.a_mask    = 4'hF;
    tl_i.a_source  = 8'h11;
    tl_i.d_ready   = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp:d_valid", 64'(tl_o.d_valid), 64'd1);
      check("bp:a_ready", 64'(tl_o.a_ready), 64'd0);
      check("bp:d_data", 64'(tl_o.d_data), 64'h3);
      check("bp:d_source", 64'(tl_o.d_source), 64'h11);
      check("bp:d_opcode", 64'(tl_o.d_opcode), 64'(OpAccessAckData));
      @(posedge clk); #1;
    end
    @(negedge clk);
    tl_i.d_ready   = 1'b1;
    tl_i.a_address = 32'h004;
    tl_i.a_source  = 8'h22;
    @(posedge clk); #1;
    check("bp_hs:d_valid", 64'(tl_o.d_valid), 64'd0);
    check("bp_hs:a_ready", 64'(tl_o.a_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_next:d_valid", 64'(tl_o.d_valid), 64'd1);
    check("bp_next:d_source", 64'(tl_o.d_source), 64'h22);
    check("bp_next:d_data", 64'(tl_o.d_data), 64'h0);
    tl_i.a_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_done:d_valid", 64'(tl_o.d_valid), 64'd0);

    // Asynchronous reset drops a pending response.
    @(negedge clk);
    tl_i.a_valid   = 1'b1;
    tl_i.a_address = 32'h000;
    tl_i.a_source  = 8'h33;
    tl_i.d_ready   = 1'b0;
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    check("arst:pre_valid", 64'(tl_o.d_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst:d_valid", 64'(tl_o.d_valid), 64'd0);
    check("arst:a_ready", 64'(tl_o.a_ready), 64'd1);
    check("arst:irq", 64'(irq), 64'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    tl_i.d_ready = 1'b1;
    rd("arst:ctrl", 32'h000, 32'h0);
    rd("arst:count", 32'h008, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tlul_timer.md
# tlul_timer

TL-UL responder occupying one 4 kB peripheral slot behind the crossbar's 1:N device socket. Provides a 64-bit free-running counter with programmable prescaler, a 64-bit compare register and a level interrupt. Accepts one request at a time and returns a registered AccessAck/AccessAckData on the D channel. Illegal accesses get `d_error` responses.

## Interface
- `PrescW`, 16: prescaler register width (1..32).
- `clk_i` input 1: clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `tl_i` input `tlul_pkg::tl_h2d_t`: A-channel request and `d_ready` from the crossbar device port.
- `tl_o` output `tlul_pkg::tl_d2h_t`: D-channel response and `a_ready` to the crossbar device port.
- `irq_o` output 1: timer interrupt, level, active high.

## Operation
- Decode uses `a_address[11:0]` only; bits above are ignored (the crossbar already selected the slot).
- Register map (32-bit, word offsets):
  - 0x000 CTRL: [0] enable, [1] irq_en.
  - 0x004 PRESCALE: [PrescW-1:0].
  - 0x008 COUNT_LO.
  - 0x00C COUNT_HI.
  - 0x010 CMP_LO.
  - 0x014 CMP_HI.
  - 0x018 STATUS: [0] pending, write-1-to-clear.
- Unimplemented bits read 0 and ignore writes.
- Legal opcodes are Get (4), PutFullData (0) and PutPartialData (1). Writes honour `a_mask` per byte for both Put opcodes.
- An access is an error if any of the following holds:
  - opcode is not one of the legal three;
  - `a_address[1:0]` is not 0;
  - `a_size` is greater than 2;
  - offset is above 0x018.
- Error accesses return `d_error`=1 and `d_data`=0, with no register side effect.
- Response fields:
  - `d_opcode` is AccessAckData (1) for Get and AccessAck (0) otherwise, including errors.
  - `d_source` and `d_size` echo the request.
  - `d_param`, `d_sink` and `d_user` are 0.
- Counter:
  - When enable=1, the prescale counter increments every cycle.
  - When the prescale counter equals PRESCALE, it returns to 0 and COUNT increments by 1, wrapping 2^64-1 to 0.
  - PRESCALE=0 means COUNT increments every cycle.
  - When enable=0, both the prescale counter and COUNT hold.
- A write to COUNT_LO/HI in the same cycle as an increment: the written bytes take the written value, unwritten bytes take the incremented value. The prescale counter is unaffected.
- Snapshot: a read of COUNT_LO latches COUNT_HI into a shadow register. A read of COUNT_HI returns the shadow, not the live value.
- Pending:
  - Set in any cycle where enable=1 and COUNT >= CMP (unsigned, 64-bit).
  - Cleared by writing 1 to STATUS[0].
  - If set and clear occur in the same cycle, set wins.
- `irq_o` = pending & irq_en, driven from flops only (no path from `tl_i`).

## Timing
- Reset values:
  - all registers, the shadow, the prescale counter and pending are 0;
  - `tl_o.d_valid`=0 and `tl_o.a_ready`=1;
  - `irq_o`=0.
- `a_ready` = !rsp_valid. Only one request is outstanding at a time, and a new request is not accepted in the cycle its predecessor's response is consumed.
- A request is accepted in cycle T (`a_valid` & `a_ready`). In cycle T+1:
  - `d_valid`=1;
  - the register write is visible;
  - read data is the value sampled at T.
- Response fields hold stable while `d_valid` & !`d_ready`.
- `d_valid` drops the cycle after `d_valid` & `d_ready`. At that point `a_ready` returns to 1.
- Maximum throughput is one transaction per 2 cycles.
- Pending rises 1 cycle after the compare condition becomes true, and `irq_o` follows in the same cycle.
- Asserting reset mid-transaction drops `d_valid` immediately (asynchronously). The pending response is lost.

## Test plan
- After reset, Get 0x008 -> at T+1 `d_valid`=1, `d_opcode`=1, `d_data`=0, `d_error`=0, `d_source` echoed.
- Put CTRL=0x1, PRESCALE=3, run 40 cycles, then read COUNT_LO -> value = floor(cycles_enabled/4) ±1.
- COUNT_HI/LO=0x0000_0000_FFFF_FFFF with PRESCALE=0 and enable set, read LO then HI -> HI shadow = 0x1 once the carry has occurred, and is consistent with LO.
- CMP=5, CTRL=0x3 -> `irq_o` rises 1 cycle after COUNT reaches 5. Write STATUS=1 while COUNT >= CMP -> pending stays 1. Set CMP=0xFFFF_FFFF_FFFF_FFFF, then write STATUS=1 -> `irq_o`=0.
- Errors, each checking `d_error`=1, no register change and the correct `d_opcode`:
  - Get 0x01C;
  - Put to 0x006;
  - opcode 3.
- Hold `d_ready`=0 for 5 cycles while `a_valid` stays high -> `a_ready`=0 and `d_*` stable throughout. Then release `d_ready` -> the next request is accepted the cycle after the handshake.
